// File: rtl/uart_cmd_rx_pkg.sv
// Shared definitions for the UART command receiver: FSM state encoding and
// the command nibble codes understood by the downstream decoder.
package uart_cmd_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_e;

  // Command nibble carried in rx_data[3:0]; rx_data[7:4] is the argument.
  localparam logic [3:0] CMD_NOP        = 4'h0;
  localparam logic [3:0] CMD_SET_GAIN   = 4'h1;
  localparam logic [3:0] CMD_SET_TRIM   = 4'h2;
  localparam logic [3:0] CMD_ADC_START  = 4'h3;
  localparam logic [3:0] CMD_ADC_STOP   = 4'h4;
  localparam logic [3:0] CMD_PLL_RELOCK = 4'h5;
  localparam logic [3:0] CMD_LDO_EN     = 4'h6;
  localparam logic [3:0] CMD_LDO_DIS    = 4'h7;
  localparam logic [3:0] CMD_STATUS     = 4'hE;
  localparam logic [3:0] CMD_SOFT_RST   = 4'hF;

  function automatic logic cmd_is_defined(input logic [3:0] c);
    case (c)
      CMD_NOP, CMD_SET_GAIN, CMD_SET_TRIM, CMD_ADC_START, CMD_ADC_STOP,
      CMD_PLL_RELOCK, CMD_LDO_EN, CMD_LDO_DIS, CMD_STATUS, CMD_SOFT_RST:
        cmd_is_defined = 1'b1;
      default:
        cmd_is_defined = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_cmd_rx_sync2.sv
// Two-flop synchronizer for a single asynchronous bit; both flops reset to INIT.
module sync2 #(
  parameter logic INIT = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) ff_q <= {2{INIT}};
    else         ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/uart_cmd_rx.sv
// UART 8N1 receiver that latches each good byte as a cmd/arg nibble pair.
// Sampling is at mid-bit, timed from the synchronized start-bit falling edge.
module uart_cmd_rx
  import uart_cmd_rx_pkg::*;
#(
  parameter int CLK_FREQUENCY = 10000000,
  parameter int BAUD_RATE     = 57600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_error,
  output logic [3:0] cmd,
  output logic [3:0] arg,
  output logic       busy
);

  // state | meaning
  // IDLE      | line idle, waiting for rxs low
  // START     | timing to start-bit middle, glitch check
  // DATA      | sampling 8 data bits LSB first at mid-bit
  // STOP      | sampling stop bit; deliver byte or flag frame error
  // WAIT_IDLE | after a framing error, wait for a full bit time of idle

  localparam int DIVISOR = CLK_FREQUENCY / BAUD_RATE;
  localparam int HALF    = DIVISOR / 2;
  localparam int CNT_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             rxs;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [3:0]       arg_q, arg_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_error_q, frame_error_d;

  sync2 #(.INIT(1'b1)) u_sync_rx (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (RX),
    .q_o    (rxs)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      shreg_q       <= '0;
      rx_data_q     <= '0;
      cmd_q         <= '0;
      arg_q         <= '0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shreg_q       <= shreg_d;
      rx_data_q     <= rx_data_d;
      cmd_q         <= cmd_d;
      arg_q         <= arg_d;
      rx_valid_q    <= rx_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shreg_d       = shreg_q;
    rx_data_d     = rx_data_q;
    cmd_d         = cmd_q;
    arg_d         = arg_q;
    rx_valid_d    = 1'b0;
    frame_error_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          cnt_d   = '0;
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          if (rxs) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = ST_DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          shreg_d[idx_q] = rxs;
          cnt_d          = '0;
          if (idx_q == 3'd7) state_d = ST_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // Returning to IDLE at the stop-bit middle leaves half a bit of slack
      // for a back-to-back start bit.
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            rx_data_d  = shreg_q;
            cmd_d      = shreg_q[3:0];
            arg_d      = shreg_q[7:4];
            rx_valid_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            frame_error_d = 1'b1;
            state_d       = ST_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // Counts consecutive idle cycles; any low restarts the count so a
      // held break yields only the single frame error already reported.
      ST_WAIT_IDLE: begin
        if (!rxs) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rx_data     = rx_data_q;
  assign cmd         = cmd_q;
  assign arg         = arg_q;
  assign rx_valid    = rx_valid_q;
  assign frame_error = frame_error_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed + random bench for uart_cmd_rx at 16 clocks per bit.
module tb_uart_cmd_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       RX;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic [3:0] cmd;
  logic [3:0] arg;
  logic       busy;

  int errors = 0;
  int checks = 0;

  int         cyc = 0;
  int         ferr_cnt = 0;
  int         both_cnt = 0;
  logic [7:0] vq[$];
  logic [7:0] nq[$];
  int         cq[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_cmd_rx #(
    .CLK_FREQUENCY(1600),
    .BAUD_RATE    (100)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_error (frame_error),
    .cmd         (cmd),
    .arg         (arg),
    .busy        (busy)
  );

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rx_valid) begin
      vq.push_back(rx_data);
      nq.push_back({arg, cmd});
      cq.push_back(cyc);
    end
    if (frame_error) ferr_cnt = ferr_cnt + 1;
    if (rx_valid && frame_error) both_cnt = both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One 8N1 frame; per_x10 is the bit period in tenths of a clock.
  task automatic send_frame(input logic [7:0] b, input int per_x10, input logic stop_v);
    logic [9:0] bits;
    bits = {stop_v, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      RX = bits[k];
      step(((k + 1) * per_x10 + 5) / 10 - (k * per_x10 + 5) / 10);
    end
  endtask

  task automatic compare_rx(input string tag);
    logic [7:0] d, n, e;
    check({tag, "_count"}, vq.size(), exp_q.size());
    while (vq.size() > 0 && exp_q.size() > 0) begin
      d = vq.pop_front();
      n = nq.pop_front();
      e = exp_q.pop_front();
      check({tag, "_data"}, d, e);
      check({tag, "_cmd"}, n[3:0], e % 16);
      check({tag, "_arg"}, n[7:4], e / 16);
    end
    vq.delete();
    nq.delete();
    cq.delete();
    exp_q.delete();
  endtask

  initial begin
    int         t0, lat, gap, ferr0;
    logic [7:0] b;
    logic       dropped;

    // Reset state
    rst_n = 1'b0;
    RX    = 1'b1;
    step(3);
    check("rst_rx_data", rx_data, 0);
    check("rst_cmd", cmd, 0);
    check("rst_arg", arg, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_ferr", frame_error, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    step(5);

    // Single byte 0xA5 and latency
    t0 = cyc;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 160, 1'b1);
    step(10);
    if (cq.size() > 0) lat = cq[0] - t0 - 1;
    else               lat = -1;
    check("latency_window", (lat >= 154 && lat <= 156), 1);
    check("a5_ferr", ferr_cnt, 0);
    compare_rx("a5");

    // Back-to-back 0x3C, 0xC3
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    send_frame(8'h3C, 160, 1'b1);
    send_frame(8'hC3, 160, 1'b1);
    step(10);
    if (cq.size() == 2) gap = cq[1] - cq[0];
    else                gap = -1;
    check("b2b_spacing", (gap >= 159 && gap <= 161), 1);
    compare_rx("b2b");

    // 4-cycle glitch
    RX = 1'b0;
    step(4);
    RX = 1'b1;
    dropped = 1'b0;
    for (int i = 0; i < 12 && !dropped; i++) begin
      step(1);
      if (!busy) dropped = 1'b1;
    end
    check("glitch_busy_drop", dropped, 1);
    step(30);
    check("glitch_busy_idle", busy, 0);
    check("glitch_ferr", ferr_cnt, 0);
    compare_rx("glitch");

    // Framing error then long break, then recovery with 0x81
    ferr0 = ferr_cnt;
    send_frame(8'h55, 160, 1'b0);
    RX = 1'b0;
    step(40);
    RX = 1'b1;
    step(24);
    check("ferr_once", ferr_cnt - ferr0, 1);
    check("ferr_keep_data", rx_data, 8'hC3);
    check("ferr_keep_cmd", cmd, 4'h3);
    check("ferr_keep_arg", arg, 4'hC);
    compare_rx("ferr_novalid");
    exp_q.push_back(8'h81);
    send_frame(8'h81, 160, 1'b1);
    step(10);
    compare_rx("after_ferr");

    // Reset during data bit 4 of 0xFF
    RX = 1'b0;
    step(16);
    RX = 1'b1;
    step(72);
    rst_n = 1'b0;
    step(3);
    check("midrst_data", rx_data, 0);
    check("midrst_cmd", cmd, 0);
    check("midrst_arg", arg, 0);
    check("midrst_valid", rx_valid, 0);
    check("midrst_ferr", frame_error, 0);
    check("midrst_busy", busy, 0);
    rst_n = 1'b1;
    step(100);
    compare_rx("midrst_novalid");
    exp_q.push_back(8'h12);
    send_frame(8'h12, 160, 1'b1);
    step(10);
    compare_rx("after_midrst");

    // Random bytes at -2% and +2% baud error
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 8; i++) begin
        b = 8'($urandom_range(0, 255));
        exp_q.push_back(b);
        send_frame(b, (p == 0) ? 157 : 163, 1'b1);
        RX = 1'b1;
        step($urandom_range(0, 4));
      end
    end
    step(30);
    check("rand_ferr", ferr_cnt, 1);
    compare_rx("rand");

    check("valid_ferr_exclusive", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
